// File: rtl/minmax_range_monitor_if.sv
// Bundle of the monitor's data inputs, programming inputs and status outputs.
// The master modport belongs to whoever drives the tracker pair and the
// alarm programming; the slave modport is the monitor itself.
// Optional RANGE_PEAK_EN adds the peak_range_o status signal.
interface minmax_range_monitor_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic                    in_valid_i;
    logic signed [WIDTH-1:0] max_i;
    logic signed [WIDTH-1:0] min_i;
    logic [WIDTH:0]          threshold_i;
    logic [WIDTH:0]          hyst_i;
    logic                    clear_count_i;
    logic [WIDTH:0]          range_o;
    logic                    range_valid_o;
    logic                    pair_err_o;
    logic                    alarm_o;
    logic [CNT_W-1:0]        event_count_o;
`ifdef RANGE_PEAK_EN
    logic [WIDTH:0]          peak_range_o;

    modport master (
        output in_valid_i, max_i, min_i, threshold_i, hyst_i, clear_count_i,
        input  range_o, range_valid_o, pair_err_o, alarm_o, event_count_o,
               peak_range_o
    );
    modport slave (
        input  in_valid_i, max_i, min_i, threshold_i, hyst_i, clear_count_i,
        output range_o, range_valid_o, pair_err_o, alarm_o, event_count_o,
               peak_range_o
    );
`else
    modport master (
        output in_valid_i, max_i, min_i, threshold_i, hyst_i, clear_count_i,
        input  range_o, range_valid_o, pair_err_o, alarm_o, event_count_o
    );
    modport slave (
        input  in_valid_i, max_i, min_i, threshold_i, hyst_i, clear_count_i,
        output range_o, range_valid_o, pair_err_o, alarm_o, event_count_o
    );
`endif
endinterface

// File: rtl/minmax_range_monitor.sv
// Range monitor for the running max/min tracker: range = max - min, with a
// debounced, hysteretic over-range alarm and a saturating alarm-entry counter.
// Two-stage pipeline: S1 registers the pair, S2 registers range/pair_err and
// the FSM, so alarm and event_count change together with range_valid.
// Optional feature macro: RANGE_PEAK_EN (adds peak_range_o).
// HOLD_CYCLES must be >= 1.
module minmax_range_monitor #(
    parameter int WIDTH       = 32,
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    minmax_range_monitor_if.slave bus
);
    localparam int HCNT_W = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_NORMAL, ST_PENDING, ST_ALARM} state_t;

    logic                    s1_valid_q;
    logic signed [WIDTH-1:0] s1_max_q;
    logic signed [WIDTH-1:0] s1_min_q;
    logic [WIDTH:0]          diff_w;
    logic                    err_w;
    logic [WIDTH:0]          range_w;
    logic [WIDTH:0]          clear_lvl_w;
    logic                    over_w;
    logic                    below_w;
    logic [WIDTH:0]          range_q;
    logic                    range_valid_q;
    logic                    pair_err_q;
    state_t                  state_q, state_d;
    logic [HCNT_W-1:0]       hold_q, hold_d;
    logic                    entry_w;
    logic                    alarm_q;
    logic [CNT_W-1:0]        count_q;

    // S1: capture the tracker pair and its valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_max_q   <= '0;
            s1_min_q   <= '0;
        end else begin
            s1_valid_q <= bus.in_valid_i;
            if (bus.in_valid_i) begin
                s1_max_q <= bus.max_i;
                s1_min_q <= bus.min_i;
            end
        end
    end

    // Sign-extended difference never overflows WIDTH+1 bits, so its MSB is
    // exactly "max < min". Threshold/hyst are taken live at this stage.
    assign diff_w      = {s1_max_q[WIDTH-1], s1_max_q} - {s1_min_q[WIDTH-1], s1_min_q};
    assign err_w       = diff_w[WIDTH];
    assign range_w     = err_w ? '0 : diff_w;
    assign clear_lvl_w = (bus.threshold_i >= bus.hyst_i) ? (bus.threshold_i - bus.hyst_i) : '0;
    assign over_w      = !err_w && (range_w > bus.threshold_i);
    assign below_w     = (range_w <= clear_lvl_w);

    // S2: register range, pair error and the valid strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            range_q       <= '0;
            range_valid_q <= 1'b0;
            pair_err_q    <= 1'b0;
        end else begin
            range_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                range_q    <= range_w;
                pair_err_q <= err_w;
            end
        end
    end

    // Alarm FSM next state; only a sample entering S2 can move it
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        entry_w = 1'b0;
        if (s1_valid_q) begin
            case (state_q)
                ST_IDLE, ST_NORMAL: begin
                    if (over_w) begin
                        if (HOLD_CYCLES <= 1) begin
                            state_d = ST_ALARM;
                            hold_d  = '0;
                            entry_w = 1'b1;
                        end else begin
                            state_d = ST_PENDING;
                            hold_d  = HCNT_W'(1);
                        end
                    end else begin
                        state_d = ST_NORMAL;
                        hold_d  = '0;
                    end
                end
                ST_PENDING: begin
                    if (!over_w) begin
                        state_d = ST_NORMAL;
                        hold_d  = '0;
                    end else if (32'(hold_q) + 32'd1 >= 32'(HOLD_CYCLES)) begin
                        state_d = ST_ALARM;
                        hold_d  = '0;
                        entry_w = 1'b1;
                    end else begin
                        hold_d  = hold_q + HCNT_W'(1);
                    end
                end
                ST_ALARM: begin
                    // Hysteresis band (clear level < range <= threshold) keeps the alarm
                    if (below_w) begin
                        state_d = ST_NORMAL;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    hold_d  = '0;
                end
            endcase
        end
    end

    // FSM state, debounce counter and registered alarm flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            alarm_q <= (state_d == ST_ALARM);
        end
    end

    // Saturating alarm-entry counter; a same-cycle clear and entry leaves 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (bus.clear_count_i) begin
            count_q <= entry_w ? CNT_W'(1) : '0;
        end else if (entry_w && (count_q != '1)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

`ifdef RANGE_PEAK_EN
    logic [WIDTH:0] peak_q;

    // Peak of valid (non-error) ranges; clear reloads with the current sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_q <= '0;
        end else if (bus.clear_count_i) begin
            peak_q <= (s1_valid_q && !err_w) ? range_w : '0;
        end else if (s1_valid_q && !err_w && (range_w > peak_q)) begin
            peak_q <= range_w;
        end
    end

    assign bus.peak_range_o = peak_q;
`endif

    assign bus.range_o       = range_q;
    assign bus.range_valid_o = range_valid_q;
    assign bus.pair_err_o    = pair_err_q;
    assign bus.alarm_o       = alarm_q;
    assign bus.event_count_o = count_q;
endmodule

// File: tb/tb_minmax_range_monitor.sv
// Directed bench for minmax_range_monitor: a vector table for the range path
// plus hand-written sequences for debounce, hysteresis, reset and counting.
// CNT_W is 2 so saturation (3) is reachable; a HOLD_CYCLES=1 copy shares inputs.
module tb_minmax_range_monitor;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    minmax_range_monitor_if #(.WIDTH(32), .CNT_W(2)) bus0 ();
    minmax_range_monitor_if #(.WIDTH(32), .CNT_W(2)) bus1 ();

    assign bus1.in_valid_i    = bus0.in_valid_i;
    assign bus1.max_i         = bus0.max_i;
    assign bus1.min_i         = bus0.min_i;
    assign bus1.threshold_i   = bus0.threshold_i;
    assign bus1.hyst_i        = bus0.hyst_i;
    assign bus1.clear_count_i = bus0.clear_count_i;

    minmax_range_monitor #(.WIDTH(32), .HOLD_CYCLES(4), .CNT_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    minmax_range_monitor #(.WIDTH(32), .HOLD_CYCLES(1), .CNT_W(2)) dut_h1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    typedef struct {
        logic signed [31:0] mx;
        logic signed [31:0] mn;
        logic [32:0]        exp_range;
        logic               exp_err;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One valid sample; clr is asserted in the cycle the sample reaches S2
    task automatic send(input logic signed [31:0] mx, input logic signed [31:0] mn, input logic clr);
        bus0.in_valid_i = 1'b1;
        bus0.max_i      = mx;
        bus0.min_i      = mn;
        step();
        bus0.in_valid_i    = 1'b0;
        bus0.clear_count_i = clr;
        step();
        bus0.clear_count_i = 1'b0;
        $display("txn max=%0d min=%0d clr=%0b -> range=%0d err=%0b alarm=%0b count=%0d",
                 mx, mn, clr, bus0.range_o, bus0.pair_err_o, bus0.alarm_o, bus0.event_count_o);
    endtask

    task automatic send_over(input int n);
        for (int k = 0; k < n; k++) send(32'sd90, -32'sd90, 1'b0);
    endtask

    initial begin
        vecs[0] = '{mx: 32'sd56,  mn: -32'sd8,  exp_range: 33'd64, exp_err: 1'b0};
        vecs[1] = '{mx: -32'sd12, mn: 32'sd12,  exp_range: 33'd0,  exp_err: 1'b1};
        vecs[2] = '{mx: 32'sd25,  mn: -32'sd12, exp_range: 33'd37, exp_err: 1'b0};
        vecs[3] = '{mx: 32'sh7FFFFFFF, mn: 32'sh80000000, exp_range: 33'h0FFFFFFFF, exp_err: 1'b0};
        vecs[4] = '{mx: -32'sd5,  mn: -32'sd5,  exp_range: 33'd0,  exp_err: 1'b0};
        vecs[5] = '{mx: 32'sh80000000, mn: 32'sh7FFFFFFF, exp_range: 33'd0, exp_err: 1'b1};

        rst_n              = 1'b0;
        bus0.in_valid_i    = 1'b0;
        bus0.max_i         = '0;
        bus0.min_i         = '0;
        bus0.threshold_i   = 33'd100;
        bus0.hyst_i        = 33'd20;
        bus0.clear_count_i = 1'b0;
        step();
        step();
        check("reset range",       bus0.range_o, 0);
        check("reset range_valid", bus0.range_valid_o, 0);
        check("reset pair_err",    bus0.pair_err_o, 0);
        check("reset alarm",       bus0.alarm_o, 0);
        check("reset count",       bus0.event_count_o, 0);
        rst_n = 1'b1;
        step();

        // Pipeline latency: valid appears exactly two cycles after in_valid
        bus0.in_valid_i = 1'b1;
        bus0.max_i      = 32'sd56;
        bus0.min_i      = -32'sd8;
        step();
        bus0.in_valid_i = 1'b0;
        check("lat cycle1 valid", bus0.range_valid_o, 0);
        step();
        check("lat cycle2 valid", bus0.range_valid_o, 1);
        check("lat cycle2 range", bus0.range_o, 64);
        step();
        check("lat cycle3 valid", bus0.range_valid_o, 0);

        // Range table with the alarm threshold out of reach
        bus0.threshold_i = '1;
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].mx, vecs[i].mn, 1'b0);
            check($sformatf("vec%0d range", i), bus0.range_o, vecs[i].exp_range);
            check($sformatf("vec%0d err", i), bus0.pair_err_o, vecs[i].exp_err);
            check($sformatf("vec%0d valid", i), bus0.range_valid_o, 1);
        end
        bus0.threshold_i = 33'd100;

        // Range equal to threshold is not over
        for (int k = 0; k < 4; k++) send(32'sd50, -32'sd50, 1'b0);
        check("equal thr alarm", bus0.alarm_o, 0);

        // Debounce
        send_over(1);
        check("deb1 alarm", bus0.alarm_o, 0);
        check("h1 alarm first", bus1.alarm_o, 1);
        check("h1 count first", bus1.event_count_o, 1);
        send_over(2);
        check("deb3 alarm", bus0.alarm_o, 0);
        send_over(1);
        check("deb4 alarm", bus0.alarm_o, 1);
        check("deb4 count", bus0.event_count_o, 1);
        send(32'sd3, -32'sd8, 1'b0);
        check("exit alarm", bus0.alarm_o, 0);
        send_over(3);
        check("three over alarm", bus0.alarm_o, 0);
        send(32'sd3, -32'sd8, 1'b0);
        send_over(1);
        check("debounce restart", bus0.alarm_o, 0);
        send(32'sd3, -32'sd8, 1'b0);

        // Hysteresis
        send_over(4);
        check("hyst enter", bus0.alarm_o, 1);
        check("hyst count", bus0.event_count_o, 2);
        send(32'sd45, -32'sd40, 1'b0);
        check("band 85 alarm", bus0.alarm_o, 1);
        send(32'sd40, -32'sd40, 1'b0);
        check("clear 80 alarm", bus0.alarm_o, 0);

        // Pair error
        send(-32'sd12, 32'sd12, 1'b0);
        check("perr range", bus0.range_o, 0);
        check("perr flag", bus0.pair_err_o, 1);
        send_over(2);
        send(-32'sd12, 32'sd12, 1'b0);
        send_over(2);
        check("perr breaks debounce", bus0.alarm_o, 0);
        send(32'sd25, -32'sd12, 1'b0);
        check("after perr range", bus0.range_o, 37);
        check("after perr flag", bus0.pair_err_o, 0);

        // Asynchronous reset in the middle of PENDING
        send_over(2);
        #3 rst_n = 1'b0;
        #1;
        check("async range", bus0.range_o, 0);
        check("async valid", bus0.range_valid_o, 0);
        check("async count", bus0.event_count_o, 0);
        check("async alarm", bus0.alarm_o, 0);
        step();
        rst_n = 1'b1;
        step();
        send_over(3);
        check("post reset 3 alarm", bus0.alarm_o, 0);
        send_over(1);
        check("post reset 4 alarm", bus0.alarm_o, 1);
        check("post reset count", bus0.event_count_o, 1);

        // Hysteresis larger than threshold: clear level is 0
        bus0.hyst_i = 33'd200;
        send(32'sd3, -32'sd8, 1'b0);
        check("sat clear holds", bus0.alarm_o, 1);
        send(-32'sd12, 32'sd12, 1'b0);
        check("sat clear by zero", bus0.alarm_o, 0);
        bus0.hyst_i = 33'd20;

        // Counter saturation at 3
        send_over(4);
        send(32'sd3, -32'sd8, 1'b0);
        send_over(4);
        check("count 3", bus0.event_count_o, 3);
        send(32'sd3, -32'sd8, 1'b0);
        send_over(4);
        check("count saturated", bus0.event_count_o, 3);
        check("sat alarm", bus0.alarm_o, 1);
        send(32'sd3, -32'sd8, 1'b0);
        send_over(3);
        send(32'sd90, -32'sd90, 1'b1);
        check("clear with entry", bus0.event_count_o, 1);
        send(32'sd3, -32'sd8, 1'b0);
        bus0.clear_count_i = 1'b1;
        step();
        bus0.clear_count_i = 1'b0;
        check("clear alone", bus0.event_count_o, 0);

`ifdef RANGE_PEAK_EN
        send(32'sd32, -32'sd32, 1'b1);
        check("peak after clear", bus0.peak_range_o, 64);
        send(32'sd90, -32'sd90, 1'b0);
        send(32'sd25, -32'sd12, 1'b0);
        check("peak max", bus0.peak_range_o, 180);
        send(-32'sd12, 32'sd12, 1'b0);
        check("peak ignores perr", bus0.peak_range_o, 180);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
